// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
// Carries the decoded control bundle from ID through EX, MEM and WB of a
// 5-stage RV32I pipeline. Tracks the destination register of each stage and
// produces EX operand forwarding selects, load-use stalls and branch/jump
// flushes.
// Optional feature macro: PERF_CNT_EN adds stall_cnt / flush_cnt event
// counters. When the macro is undefined the counters and their ports are absent.
module pipeline_control_unit #(
   parameter int REG_AW = 5,
   parameter int ALU_CW = 3,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_write_d,
   input  logic [1:0]        result_src_d,
   input  logic              mem_write_d,
   input  logic              jump_d,
   input  logic              branch_d,
   input  logic              alu_src_d,
   input  logic [ALU_CW-1:0] alu_ctrl_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              zero_e,
   output logic              alu_src_e,
   output logic              mem_write_m,
   output logic              reg_write_w,
   output logic [ALU_CW-1:0] alu_ctrl_e,
   output logic [1:0]        result_src_w,
   output logic              pc_src_e,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // ID/EX stage registers and their next-state values
   logic              rw_e_q, mw_e_q, j_e_q, b_e_q, as_e_q;
   logic [1:0]        rs_e_q;
   logic [ALU_CW-1:0] alu_e_q;
   logic [REG_AW-1:0] rs1_e_q, rs2_e_q, rd_e_q;
   logic              rw_e_d, mw_e_d, j_e_d, b_e_d, as_e_d;
   logic [1:0]        rs_e_d;
   logic [ALU_CW-1:0] alu_e_d;
   logic [REG_AW-1:0] rs1_e_d, rs2_e_d, rd_e_d;

   // EX/MEM and MEM/WB stage registers
   logic              rw_m_q, mw_m_q, rw_w_q;
   logic [1:0]        rs_m_q, rs_w_q;
   logic [REG_AW-1:0] rd_m_q, rd_w_q;

   logic              lw_stall;

   // A younger stage wins: MEM result is newer than WB. x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (rw_m_q && (rd_m_q != '0) && (rd_m_q == rs))
         return 2'b10;
      else if (rw_w_q && (rd_w_q != '0) && (rd_w_q == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Hazard detection: forwarding, load-use stall, branch/jump redirect
   always_comb begin
      pc_src_e = (b_e_q & zero_e) | j_e_q;
      fwd_a_e  = fwd_sel(rs1_e_q);
      fwd_b_e  = fwd_sel(rs2_e_q);
      lw_stall = (rs_e_q == 2'b01) && (rd_e_q != '0) &&
                 ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));
      // A redirect squashes the instruction in ID anyway, so it beats a stall.
      stall_f  = lw_stall & ~pc_src_e;
      stall_d  = lw_stall & ~pc_src_e;
      flush_e  = lw_stall | pc_src_e;
      flush_d  = pc_src_e;
   end

   // ID/EX next state: take the ID bundle, or insert a bubble on flush_e
   always_comb begin
      rw_e_d  = reg_write_d;
      rs_e_d  = result_src_d;
      mw_e_d  = mem_write_d;
      j_e_d   = jump_d;
      b_e_d   = branch_d;
      as_e_d  = alu_src_d;
      alu_e_d = alu_ctrl_d;
      rs1_e_d = rs1_d;
      rs2_e_d = rs2_d;
      rd_e_d  = rd_d;
      if (flush_e) begin
         rw_e_d  = 1'b0;
         rs_e_d  = 2'b00;
         mw_e_d  = 1'b0;
         j_e_d   = 1'b0;
         b_e_d   = 1'b0;
         as_e_d  = 1'b0;
         alu_e_d = '0;
         rs1_e_d = '0;
         rs2_e_d = '0;
         rd_e_d  = '0;
      end
   end

   // Pipeline registers; EX/MEM and MEM/WB advance unconditionally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_e_q  <= 1'b0;
         rs_e_q  <= 2'b00;
         mw_e_q  <= 1'b0;
         j_e_q   <= 1'b0;
         b_e_q   <= 1'b0;
         as_e_q  <= 1'b0;
         alu_e_q <= '0;
         rs1_e_q <= '0;
         rs2_e_q <= '0;
         rd_e_q  <= '0;
         rw_m_q  <= 1'b0;
         rs_m_q  <= 2'b00;
         mw_m_q  <= 1'b0;
         rd_m_q  <= '0;
         rw_w_q  <= 1'b0;
         rs_w_q  <= 2'b00;
         rd_w_q  <= '0;
      end else begin
         rw_e_q  <= rw_e_d;
         rs_e_q  <= rs_e_d;
         mw_e_q  <= mw_e_d;
         j_e_q   <= j_e_d;
         b_e_q   <= b_e_d;
         as_e_q  <= as_e_d;
         alu_e_q <= alu_e_d;
         rs1_e_q <= rs1_e_d;
         rs2_e_q <= rs2_e_d;
         rd_e_q  <= rd_e_d;
         rw_m_q  <= rw_e_q;
         rs_m_q  <= rs_e_q;
         mw_m_q  <= mw_e_q;
         rd_m_q  <= rd_e_q;
         rw_w_q  <= rw_m_q;
         rs_w_q  <= rs_m_q;
         rd_w_q  <= rd_m_q;
      end
   end

   assign alu_src_e    = as_e_q;
   assign alu_ctrl_e   = alu_e_q;
   assign mem_write_m  = mw_m_q;
   assign reg_write_w  = rw_w_q;
   assign result_src_w = rs_w_q;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Event counters, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f)  stall_cnt_q <= stall_cnt_q + 1'b1;
         if (pc_src_e) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic [CNT_W-1:0] cnt_w_unused;
   assign cnt_w_unused = '0;
`endif

endmodule
